// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, trap codes and FSM state for the wasm stack-machine core
package cpu_pkg;

  localparam logic [7:0] OP_UNREACHABLE = 8'h00;
  localparam logic [7:0] OP_NOP         = 8'h01;
  localparam logic [7:0] OP_END         = 8'h0B;
  localparam logic [7:0] OP_DROP        = 8'h1A;
  localparam logic [7:0] OP_I32_CONST   = 8'h41;
  localparam logic [7:0] OP_I64_CONST   = 8'h42;
  localparam logic [7:0] OP_F32_CONST   = 8'h43;
  localparam logic [7:0] OP_F64_CONST   = 8'h44;

  localparam logic [3:0] TRAP_RUNNING     = 4'd0;
  localparam logic [3:0] TRAP_END         = 4'd1;
  localparam logic [3:0] TRAP_UNREACHABLE = 4'd2;
  localparam logic [3:0] TRAP_ILLEGAL     = 4'd3;
  localparam logic [3:0] TRAP_MEM         = 4'd4;
  localparam logic [3:0] TRAP_OVERFLOW    = 4'd5;
  localparam logic [3:0] TRAP_UNDERFLOW   = 4'd6;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_IMM    = 2'd2,
    S_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_leb128_decode.sv
// rtl/cpu_leb128_decode.sv - combinational signed LEB128 decoder over a 10-byte window
module leb128_decode (
  input  logic [79:0] window,
  input  logic        is_64,
  output logic [63:0] value,
  output logic [3:0]  len,
  output logic        valid
);

  // i32 encodings stop after 5 bytes, i64 after 10; the first clear continuation bit ends it
  always_comb begin
    value = '0;
    len   = '0;
    valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!valid && (i < 5 || is_64)) begin
        value = value | ({57'd0, window[8*i +: 7]} << (7 * i));
        if (!window[8*i + 7]) begin
          valid = 1'b1;
          len   = 4'(i + 1);
          if (window[8*i + 6] && i < 9) begin
            value = value | (~64'd0 << (7 * (i + 1)));
          end
        end
      end
    end
  end

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - wasm stack-machine core over a registered byte ROM
// define CPU_FLOAT_EN to decode f32.const/f64.const; otherwise they trap as illegal
module cpu
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH   = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [63:0]          result,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);

  localparam int AW      = MEM_DEPTH + 1;
  localparam int ENTRIES = 2 ** STACK_DEPTH;
  localparam logic [AW-1:0]        PC_ONE = AW'(1);
  localparam logic [STACK_DEPTH:0] SP_ONE = (STACK_DEPTH + 1)'(1);

`ifdef CPU_FLOAT_EN
  localparam bit FLOAT_EN = 1'b1;
`else
  localparam bit FLOAT_EN = 1'b0;
`endif

  state_t                 state;
  logic [AW-1:0]          pc;
  logic [7:0]             imm_op;
  logic [STACK_DEPTH:0]   sp;
  logic [63:0]            stack [ENTRIES];

  logic [7:0]             opcode;
  logic                   is_const;
  logic [3:0]             const_extra;
  logic [63:0]            leb_value;
  logic [3:0]             leb_len;
  logic                   leb_valid;
  logic [63:0]            imm_value;
  logic [3:0]             imm_len;
  logic                   imm_ok;
  logic                   full;
  logic                   push_en;
  logic [STACK_DEPTH-1:0] top_idx;
  logic                   unused_bits;

  assign opcode      = mem_data[7:0];
  assign unused_bits = ^mem_data[127:80];

  always_comb begin
    is_const    = 1'b0;
    const_extra = 4'd0;
    case (opcode)
      OP_I32_CONST: begin is_const = 1'b1; const_extra = 4'd4; end
      OP_I64_CONST: begin is_const = 1'b1; const_extra = 4'd9; end
      OP_F32_CONST: if (FLOAT_EN) begin is_const = 1'b1; const_extra = 4'd3; end
      OP_F64_CONST: if (FLOAT_EN) begin is_const = 1'b1; const_extra = 4'd7; end
      default: ;
    endcase
  end

  // The ROM is registered, so the address must be presented in the cycle before the data is used
  always_comb begin
    mem_addr  = pc;
    mem_extra = 4'd0;
    if (state == S_DECODE && is_const) begin
      mem_addr  = pc + PC_ONE;
      mem_extra = const_extra;
    end
  end

  leb128_decode u_leb (
    .window (mem_data[79:0]),
    .is_64  (imm_op == OP_I64_CONST),
    .value  (leb_value),
    .len    (leb_len),
    .valid  (leb_valid)
  );

  always_comb begin
    imm_value = leb_value;
    imm_len   = leb_len;
    imm_ok    = leb_valid;
    case (imm_op)
      OP_I32_CONST: imm_value = {32'd0, leb_value[31:0]};
      OP_F32_CONST: begin imm_value = {32'd0, mem_data[31:0]}; imm_len = 4'd4; imm_ok = 1'b1; end
      OP_F64_CONST: begin imm_value = mem_data[63:0];          imm_len = 4'd8; imm_ok = 1'b1; end
      default: ;
    endcase
  end

  assign full         = sp[STACK_DEPTH];
  assign result_empty = (sp == '0);
  assign top_idx      = STACK_DEPTH'(sp - SP_ONE);
  assign result       = result_empty ? 64'd0 : stack[top_idx];
  assign push_en      = (state == S_IMM) && !mem_error && imm_ok && !full;

  always_ff @(posedge clk) begin
    if (push_en) begin
      stack[sp[STACK_DEPTH-1:0]] <= imm_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      sp     <= '0;
      trap   <= TRAP_RUNNING;
      imm_op <= 8'h00;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (mem_error) begin
            trap  <= TRAP_MEM;
            state <= S_HALT;
          end else if (is_const) begin
            imm_op <= opcode;
            state  <= S_IMM;
          end else begin
            case (opcode)
              OP_NOP: begin
                pc    <= pc + PC_ONE;
                state <= S_FETCH;
              end
              OP_DROP: begin
                if (sp == '0) begin
                  trap  <= TRAP_UNDERFLOW;
                  state <= S_HALT;
                end else begin
                  sp    <= sp - SP_ONE;
                  pc    <= pc + PC_ONE;
                  state <= S_FETCH;
                end
              end
              OP_END: begin
                trap  <= TRAP_END;
                state <= S_HALT;
              end
              OP_UNREACHABLE: begin
                trap  <= TRAP_UNREACHABLE;
                state <= S_HALT;
              end
              default: begin
                trap  <= TRAP_ILLEGAL;
                state <= S_HALT;
              end
            endcase
          end
        end
        S_IMM: begin
          if (mem_error) begin
            trap  <= TRAP_MEM;
            state <= S_HALT;
          end else if (!imm_ok) begin
            trap  <= TRAP_ILLEGAL;
            state <= S_HALT;
          end else if (full) begin
            trap  <= TRAP_OVERFLOW;
            state <= S_HALT;
          end else begin
            sp    <= sp + SP_ONE;
            pc    <= pc + AW'(imm_len) + PC_ONE;
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu against a bytecode interpreter model
module tb_cpu;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  result;
  logic         result_empty;
  logic [3:0]   trap;
  logic [6:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data = '0;
  logic         mem_error = 1'b0;

  logic [7:0]   rom [128];
  int           rom_upper = 127;
  int           wp = 0;
  int           checks = 0;
  int           errors = 0;

  logic [3:0]   m_trap;
  logic [63:0]  m_top;
  logic         m_empty;

`ifdef CPU_FLOAT_EN
  localparam bit FLOAT = 1'b1;
`else
  localparam bit FLOAT = 1'b0;
`endif

  cpu #(.MEM_DEPTH(6), .STACK_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_empty (result_empty),
    .trap         (trap),
    .mem_addr     (mem_addr),
    .mem_extra    (mem_extra),
    .mem_data     (mem_data),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input int a);
    if (a >= 0 && a <= rom_upper && a < 128) return rom[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin : rom_model
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 16; i++)
      if (i <= int'(mem_extra)) d[8*i +: 8] = rd(int'(mem_addr) + i);
    mem_data  <= d;
    mem_error <= int'(mem_addr) > rom_upper;
  end

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    wp = 0;
  endtask

  task automatic emit(input logic [7:0] b);
    rom[wp] = b;
    wp++;
  endtask

  task automatic load_bytes(input logic [319:0] v, input int n, input int upper);
    clear_rom();
    for (int i = 0; i < n; i++) emit(v[8*(n-1-i) +: 8]);
    rom_upper = (upper < 0) ? n - 1 : upper;
  endtask

  task automatic run_prog(input string name);
    int cyc;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (trap == 4'd0 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (trap == 4'd0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: trap=0 after %0d cycles, want nonzero", name, cyc);
    end
  endtask

  // Interprets the ROM one instruction at a time, independent of cycle timing
  task automatic model();
    logic [63:0] st[$];
    logic [7:0]  op, b;
    logic [63:0] v;
    int          pc, n, maxn;
    bit          ok;
    st = {};
    pc = 0;
    m_trap = 4'd0;
    for (int step = 0; step < 300 && m_trap == 4'd0; step++) begin
      if (pc > rom_upper) m_trap = 4'd4;
      else begin
        op = rd(pc);
        if (op == 8'h01) pc++;
        else if (op == 8'h0B) m_trap = 4'd1;
        else if (op == 8'h00) m_trap = 4'd2;
        else if (op == 8'h1A) begin
          if (st.size() == 0) m_trap = 4'd6;
          else begin void'(st.pop_back()); pc++; end
        end else if (op == 8'h41 || op == 8'h42 || (FLOAT && (op == 8'h43 || op == 8'h44))) begin
          if (pc + 1 > rom_upper) m_trap = 4'd4;
          else begin
            v = 64'd0; n = 0; ok = 1'b0;
            if (op == 8'h43 || op == 8'h44) begin
              n = (op == 8'h43) ? 4 : 8;
              ok = 1'b1;
              for (int k = 0; k < n; k++) v[8*k +: 8] = rd(pc + 1 + k);
            end else begin
              maxn = (op == 8'h41) ? 5 : 10;
              for (int k = 0; k < maxn && !ok; k++) begin
                b = rd(pc + 1 + k);
                v = v | (64'(b[6:0]) << (7 * k));
                if (!b[7]) begin
                  ok = 1'b1;
                  n = k + 1;
                  if (b[6] && n < 10) v = v | (~64'd0 << (7 * n));
                end
              end
              if (op == 8'h41) v = v & 64'h0000_0000_FFFF_FFFF;
            end
            if (!ok) m_trap = 4'd3;
            else if (st.size() == 16) m_trap = 4'd5;
            else begin st.push_back(v); pc += 1 + n; end
          end
        end else m_trap = 4'd3;
      end
    end
    m_empty = (st.size() == 0);
    m_top   = m_empty ? 64'd0 : st[st.size()-1];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (result_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", result_empty); end
    checks++; if (trap !== 4'd0) begin errors++; $display("FAIL reset_trap got=%0d want=0", trap); end
    checks++; if (mem_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_extra !== 4'd0) begin errors++; $display("FAIL reset_extra got=%0d want=0", mem_extra); end
  endtask

  task automatic test_f64_example();
    logic [3:0] exp_trap;
    load_bytes(80'h44_00_00_00_00_00_00_00_C0_0B, 10, -1);
`ifdef CPU_FLOAT_EN
    exp_trap = 4'd1;
`else
    exp_trap = 4'd3;
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
`ifdef CPU_FLOAT_EN
      if (e == 4) begin
        checks++;
        if (result !== 64'hC000_0000_0000_0000) begin
          errors++; $display("FAIL f64_result_edge4 got=%h want=c000000000000000", result);
        end
      end
`endif
      if (e == 6) begin
        checks++; if (trap !== exp_trap) begin errors++; $display("FAIL f64_trap_edge6 got=%0d want=%0d", trap, exp_trap); end
        checks++; if (result_empty !== !FLOAT) begin errors++; $display("FAIL f64_empty got=%b want=%b", result_empty, !FLOAT); end
      end
    end
  endtask

  task automatic test_const();
    load_bytes(24'h41_7F_0B, 3, -1);
    run_prog("i32_neg1");
    checks++; if (result !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL i32_neg1 result got=%h want=00000000ffffffff", result); end
    checks++; if (trap !== 4'd1) begin errors++; $display("FAIL i32_neg1 trap got=%0d want=1", trap); end
    load_bytes(32'h42_80_01_0B, 4, -1);
    run_prog("i64_128");
    checks++; if (result !== 64'd128) begin errors++; $display("FAIL i64_128 result got=%h want=80", result); end
    checks++; if (trap !== 4'd1) begin errors++; $display("FAIL i64_128 trap got=%0d want=1", trap); end
    load_bytes(40'h41_E5_8E_26_0B, 5, -1);
    run_prog("i32_624485");
    checks++; if (result !== 64'd624485) begin errors++; $display("FAIL i32_624485 result got=%0d want=624485", result); end
    load_bytes(96'h42_FF_FF_FF_FF_FF_FF_FF_FF_FF_7F_0B, 12, -1);
    run_prog("i64_10byte");
    checks++; if (result !== ~64'd0 || trap !== 4'd1) begin errors++; $display("FAIL i64_10byte result=%h trap=%0d want=ffffffffffffffff trap=1", result, trap); end
  endtask

  task automatic test_stack();
    load_bytes(48'h41_05_41_07_1A_0B, 6, -1);
    run_prog("push_drop");
    checks++; if (result !== 64'd5) begin errors++; $display("FAIL push_drop result got=%0d want=5", result); end
    checks++; if (result_empty !== 1'b0) begin errors++; $display("FAIL push_drop empty got=%b want=0", result_empty); end
    checks++; if (trap !== 4'd1) begin errors++; $display("FAIL push_drop trap got=%0d want=1", trap); end
    load_bytes(16'h1A_0B, 2, -1);
    run_prog("underflow");
    checks++; if (trap !== 4'd6) begin errors++; $display("FAIL underflow trap got=%0d want=6", trap); end
    checks++; if (result_empty !== 1'b1 || result !== 64'd0) begin errors++; $display("FAIL underflow empty=%b result=%h want empty=1 result=0", result_empty, result); end
  endtask

  task automatic test_traps();
    load_bytes(8'h00, 1, -1);
    run_prog("unreachable");
    checks++; if (trap !== 4'd2) begin errors++; $display("FAIL unreachable trap got=%0d want=2", trap); end
    load_bytes(8'hFF, 1, -1);
    run_prog("illegal");
    checks++; if (trap !== 4'd3) begin errors++; $display("FAIL illegal trap got=%0d want=3", trap); end
    load_bytes(56'h41_80_80_80_80_80_0B, 7, -1);
    run_prog("leb_unterminated");
    checks++; if (trap !== 4'd3 || result_empty !== 1'b1) begin errors++; $display("FAIL leb_unterminated trap=%0d empty=%b want trap=3 empty=1", trap, result_empty); end
    clear_rom();
    for (int k = 1; k <= 16; k++) begin emit(8'h41); emit(8'(k)); end
    emit(8'h41); emit(8'h11); emit(8'h0B);
    rom_upper = wp - 1;
    run_prog("overflow");
    checks++; if (trap !== 4'd5) begin errors++; $display("FAIL overflow trap got=%0d want=5", trap); end
    checks++; if (result !== 64'd16 || result_empty !== 1'b0) begin errors++; $display("FAIL overflow top=%0d empty=%b want top=16 empty=0", result, result_empty); end
  endtask

  task automatic test_mem_error();
    load_bytes(32'h01_01_01_0B, 4, 2);
    run_prog("fetch_oob");
    checks++; if (trap !== 4'd4) begin errors++; $display("FAIL fetch_oob trap got=%0d want=4", trap); end
    load_bytes(24'h41_05_0B, 3, 0);
    run_prog("imm_oob");
    checks++; if (trap !== 4'd4 || result_empty !== 1'b1) begin errors++; $display("FAIL imm_oob trap=%0d empty=%b want trap=4 empty=1", trap, result_empty); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    clear_rom();
    emit(8'h41); emit(8'h05);
    repeat (20) emit(8'h01);
    emit(8'h0B);
    rom_upper = wp - 1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (result !== 64'd5) begin errors++; $display("FAIL midrun_pre result got=%0d want=5", result); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (result !== 64'd0 || result_empty !== 1'b1) begin errors++; $display("FAIL midrun_reset result=%h empty=%b want 0/1", result, result_empty); end
    checks++; if (trap !== 4'd0 || mem_addr !== 7'd0 || mem_extra !== 4'd0) begin errors++; $display("FAIL midrun_reset trap=%0d addr=%0d extra=%0d want 0/0/0", trap, mem_addr, mem_extra); end
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (trap == 4'd0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (trap !== 4'd1) begin errors++; $display("FAIL midrun_restart trap got=%0d want=1", trap); end
    checks++; if (result !== 64'd5 || result_empty !== 1'b0) begin errors++; $display("FAIL midrun_restart result=%0d empty=%b want 5/0", result, result_empty); end
  endtask

  task automatic emit_leb(input int maxn);
    int n;
    logic [7:0] b;
    n = $urandom_range(1, maxn);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom) & 8'h7F;
      if (k < n - 1) b = b | 8'h80;
      else if (n == maxn && $urandom_range(0, 5) == 0) b = b | 8'h80;
      emit(b);
    end
  endtask

  task automatic gen_random();
    int n_ops, r;
    clear_rom();
    n_ops = $urandom_range(1, 8);
    for (int i = 0; i < n_ops; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: emit(8'h01);
        2:    emit(8'h1A);
        3, 4, 9: begin emit(8'h41); emit_leb(5); end
        5, 6: begin emit(8'h42); emit_leb(10); end
        7: begin
          if ($urandom_range(0, 1) == 0) begin emit(8'h43); repeat (4) emit(8'($urandom)); end
          else begin emit(8'h44); repeat (8) emit(8'($urandom)); end
        end
        default: emit(($urandom_range(0, 2) == 0) ? 8'hFF : 8'h01);
      endcase
    end
    emit(8'h0B);
    rom_upper = ($urandom_range(0, 5) == 0) ? $urandom_range(0, wp - 1) : wp - 1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      gen_random();
      model();
      run_prog("random");
      checks++; if (trap !== m_trap) begin errors++; $display("FAIL random%0d trap got=%0d want=%0d", it, trap, m_trap); end
      checks++; if (result_empty !== m_empty) begin errors++; $display("FAIL random%0d empty got=%b want=%b", it, result_empty, m_empty); end
      checks++; if (result !== m_top) begin errors++; $display("FAIL random%0d result got=%h want=%h", it, result, m_top); end
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_f64_example();
    test_const();
    test_stack();
    test_traps();
    test_mem_error();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
